// File: rtl/sys_control_multi.sv
// sys_control_multi: per-timestep sequencer (mapping, queue routing, NUM_UNITS-wide update, internal routing, BT advance).
// Optional watchdog + ERROR state under `SYSCTRL_WATCHDOG_EN`; every output is registered.
module sys_control_multi #(
  parameter int BT_WIDTH       = 36,
  parameter int DELTAT_WIDTH   = 4,
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Initialize,
  input  logic                    Run,
  input  logic [DELTAT_WIDTH-1:0] DeltaT,
  input  logic                    IsInputQueueEmpty,
  input  logic [BT_WIDTH-1:0]     InputBT_Head,
  input  logic                    IsAuxQueueEmpty,
  input  logic [BT_WIDTH-1:0]     AuxBT_Head,
  output logic                    InputDequeue,
  output logic                    AuxDequeue,
  output logic                    InputRouteInputSelect,
  output logic                    InputRouteEnable,
  input  logic                    InputRoutingComplete,
  output logic                    MapNeurons,
  input  logic [NUM_UNITS-1:0]    MappingComplete,
  output logic [NUM_UNITS-1:0]    UpdateEnable,
  input  logic [NUM_UNITS-1:0]    UpdateComplete,
  output logic                    InternalRouteEnable,
  input  logic                    InternalRoutingComplete,
  output logic [BT_WIDTH-1:0]     Current_BT,
  output logic                    InitializationComplete,
  output logic                    Timeout
);

  typedef enum logic [3:0] {
    IDLE, INIT, READY, SELECT, ROUTE, UPDATE, INTERNAL, ADVANCE
`ifdef SYSCTRL_WATCHDOG_EN
    , ERROR
`endif
  } state_t;

  state_t state, nextState;

  logic [NUM_UNITS-1:0] mapDone, mapDoneD;
  logic [NUM_UNITS-1:0] updDone, updDoneD;
  logic [NUM_UNITS-1:0] updEnD;
  logic [BT_WIDTH-1:0]  btD;
  logic inDeqD, auxDeqD, selD, routeEnD, mapD, intEnD, initDoneD;
  logic auxReady, inReady;

  assign auxReady = !IsAuxQueueEmpty && (AuxBT_Head <= Current_BT);
  assign inReady  = !IsInputQueueEmpty && (InputBT_Head <= Current_BT);

`ifdef SYSCTRL_WATCHDOG_EN
  logic [31:0] wdCnt;
  logic        wdActive;
  logic        timeoutD;
  assign wdActive = (state == INIT) || (state == ROUTE) || (state == UPDATE) || (state == INTERNAL);
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state                  <= IDLE;
      mapDone                <= '0;
      updDone                <= '0;
      InputDequeue           <= 1'b0;
      AuxDequeue             <= 1'b0;
      InputRouteInputSelect  <= 1'b0;
      InputRouteEnable       <= 1'b0;
      MapNeurons             <= 1'b0;
      UpdateEnable           <= '0;
      InternalRouteEnable    <= 1'b0;
      Current_BT             <= '0;
      InitializationComplete <= 1'b0;
    end else begin
      state                  <= nextState;
      mapDone                <= mapDoneD;
      updDone                <= updDoneD;
      InputDequeue           <= inDeqD;
      AuxDequeue             <= auxDeqD;
      InputRouteInputSelect  <= selD;
      InputRouteEnable       <= routeEnD;
      MapNeurons             <= mapD;
      UpdateEnable           <= updEnD;
      InternalRouteEnable    <= intEnD;
      Current_BT             <= btD;
      InitializationComplete <= initDoneD;
    end
  end

`ifdef SYSCTRL_WATCHDOG_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wdCnt   <= '0;
      Timeout <= 1'b0;
    end else begin
      wdCnt   <= (nextState != state || !wdActive) ? '0 : wdCnt + 32'd1;
      Timeout <= timeoutD;
    end
  end
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (Initialize) nextState = INIT;
      INIT:     if (&(mapDone | MappingComplete)) nextState = READY;
      READY:    if (Run) nextState = SELECT;
      SELECT:   nextState = (auxReady || inReady) ? ROUTE : UPDATE;
      ROUTE:    if (InputRoutingComplete) nextState = SELECT;
      UPDATE:   if (&(updDone | UpdateComplete)) nextState = INTERNAL;
      INTERNAL: if (InternalRoutingComplete) nextState = ADVANCE;
      ADVANCE:  nextState = (!Run && IsInputQueueEmpty && IsAuxQueueEmpty) ? READY : SELECT;
      default:  nextState = state;
    endcase
`ifdef SYSCTRL_WATCHDOG_EN
    // A stuck handshake overrides whatever the wait state would have done.
    if (wdActive && wdCnt == 32'(TIMEOUT_CYCLES - 1)) nextState = ERROR;
`endif
  end

  // D-side of the output registers, derived from the state being entered.
  always_comb begin
    mapDoneD  = mapDone;
    updDoneD  = updDone;
    btD       = Current_BT;
    inDeqD    = 1'b0;
    auxDeqD   = 1'b0;
    selD      = InputRouteInputSelect;
    case (state)
      IDLE:    mapDoneD = '0;
      INIT:    mapDoneD = mapDone | MappingComplete;
      SELECT: begin
        auxDeqD  = auxReady;
        inDeqD   = !auxReady && inReady;
        selD     = auxReady;
        updDoneD = '0;
      end
      UPDATE:  updDoneD = updDone | UpdateComplete;
      ADVANCE: btD = Current_BT + BT_WIDTH'(DeltaT);
      default: ;
    endcase
    if (nextState != ROUTE) selD = 1'b0;
    initDoneD = InitializationComplete || (state == INIT && nextState == READY);
    mapD      = (nextState == INIT);
    routeEnD  = (nextState == ROUTE);
    intEnD    = (nextState == INTERNAL);
    updEnD    = (nextState == UPDATE) ? ~updDoneD : '0;
`ifdef SYSCTRL_WATCHDOG_EN
    timeoutD  = (nextState == ERROR);
`endif
  end

endmodule

// File: tb/tb_sys_control_multi.sv
// Bench for sys_control_multi: output-change scoreboard on the main instance, direct checks on a
// narrow-BT instance used for the wrap boundary.
`timescale 1ns/1ps
module tb_sys_control_multi;
  localparam int BTW = 36;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic           Reset, Initialize, Run;
  logic [3:0]     DeltaT;
  logic           IsInputQueueEmpty, IsAuxQueueEmpty;
  logic [BTW-1:0] InputBT_Head, AuxBT_Head;
  logic           InputDequeue, AuxDequeue, InputRouteInputSelect, InputRouteEnable, InputRoutingComplete;
  logic           MapNeurons;
  logic [3:0]     MappingComplete, UpdateEnable, UpdateComplete;
  logic           InternalRouteEnable, InternalRoutingComplete;
  logic [BTW-1:0] Current_BT;
  logic           InitializationComplete, Timeout;

  logic           wRun, wInDeq, wAuxDeq, wSel, wRouteEn, wMapN, wUpdEn, wIntEn, wInitDone, wTimeout;
  logic [5:0]     wBt;

  sys_control_multi #(.BT_WIDTH(BTW), .DELTAT_WIDTH(4), .NUM_UNITS(4), .TIMEOUT_CYCLES(16)) dut (
    .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .Run(Run), .DeltaT(DeltaT),
    .IsInputQueueEmpty(IsInputQueueEmpty), .InputBT_Head(InputBT_Head),
    .IsAuxQueueEmpty(IsAuxQueueEmpty), .AuxBT_Head(AuxBT_Head),
    .InputDequeue(InputDequeue), .AuxDequeue(AuxDequeue),
    .InputRouteInputSelect(InputRouteInputSelect), .InputRouteEnable(InputRouteEnable),
    .InputRoutingComplete(InputRoutingComplete), .MapNeurons(MapNeurons),
    .MappingComplete(MappingComplete), .UpdateEnable(UpdateEnable), .UpdateComplete(UpdateComplete),
    .InternalRouteEnable(InternalRouteEnable), .InternalRoutingComplete(InternalRoutingComplete),
    .Current_BT(Current_BT), .InitializationComplete(InitializationComplete), .Timeout(Timeout)
  );

  // 6-bit BT so the wrap from 2^W-8 to 0 is reachable in a few timesteps.
  sys_control_multi #(.BT_WIDTH(6), .DELTAT_WIDTH(4), .NUM_UNITS(1)) wrapDut (
    .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .Run(wRun), .DeltaT(DeltaT),
    .IsInputQueueEmpty(1'b1), .InputBT_Head(6'd0), .IsAuxQueueEmpty(1'b1), .AuxBT_Head(6'd0),
    .InputDequeue(wInDeq), .AuxDequeue(wAuxDeq), .InputRouteInputSelect(wSel),
    .InputRouteEnable(wRouteEn), .InputRoutingComplete(1'b1), .MapNeurons(wMapN),
    .MappingComplete(1'b1), .UpdateEnable(wUpdEn), .UpdateComplete(1'b1),
    .InternalRouteEnable(wIntEn), .InternalRoutingComplete(1'b1), .Current_BT(wBt),
    .InitializationComplete(wInitDone), .Timeout(wTimeout)
  );

  typedef struct packed {
    logic           inDeq, auxDeq, sel, routeEn, mapN;
    logic [3:0]     updEn;
    logic           intEn;
    logic [BTW-1:0] bt;
    logic           initDone, timeout;
  } snap_t;

  typedef struct packed {
    logic [31:0] cyc;
    snap_t       s;
  } ev_t;

  ev_t   expQ[$];
  ev_t   ev;
  snap_t e, cur;
  snap_t prev = '1;
  bit    monOn = 1'b0;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic want();
    expQ.push_back({32'(cyc), e});
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, got, req, cyc);
    end
  endtask

  // Every change of the main instance's outputs must match the next expected snapshot and cycle.
  always @(negedge Clock) begin
    if (monOn) begin
      cur = {InputDequeue, AuxDequeue, InputRouteInputSelect, InputRouteEnable, MapNeurons,
             UpdateEnable, InternalRouteEnable, Current_BT, InitializationComplete, Timeout};
      if (cur !== prev) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: cyc %0d got %h, required no change", cyc, cur);
        end else begin
          ev = expQ.pop_front();
          if (ev.cyc != 32'(cyc) || ev.s !== cur) begin
            fails++;
            $display("FAIL output_event: cyc %0d got %h, required cyc %0d snap %h", cyc, cur, ev.cyc, ev.s);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100us");
    $fatal(1, "bench timeout");
  end

  initial begin
    ev_t left;
    Reset = 1'b1; Initialize = 1'b0; Run = 1'b0; wRun = 1'b0; DeltaT = 4'd8;
    IsInputQueueEmpty = 1'b1; IsAuxQueueEmpty = 1'b1; InputBT_Head = '0; AuxBT_Head = '0;
    InputRoutingComplete = 1'b0; MappingComplete = '0; UpdateComplete = '0;
    InternalRoutingComplete = 1'b0;
    e = '0;
    #3 Reset = 1'b0;
    step(2);
    want(); monOn = 1'b1;
    Reset = 1'b1;
    step(1);

    // Mapping: unit completions in INIT cycles 3, 5, 5, 9.
    Initialize = 1'b1; step(1);
    Initialize = 1'b0; e.mapN = 1'b1; want();
    step(2); MappingComplete = 4'b0001;
    step(1); MappingComplete = 4'b0000;
    step(1); MappingComplete = 4'b0110;
    step(1); MappingComplete = 4'b0000;
    step(3); MappingComplete = 4'b1000;
    step(1); MappingComplete = 4'b0000; e.mapN = 1'b0; e.initDone = 1'b1; want();

    // Input routing: two events at BT 0, then a head of 0.5 waits for the next timestep.
    IsInputQueueEmpty = 1'b0; InputBT_Head = '0; UpdateComplete = '1;
    InternalRoutingComplete = 1'b1; Run = 1'b1;
    step(1);
    step(1); e.inDeq = 1'b1; e.routeEn = 1'b1; want(); Run = 1'b0;
    step(1); e.inDeq = 1'b0; want();
    step(1); InputRoutingComplete = 1'b1;
    step(1); e.routeEn = 1'b0; want(); InputRoutingComplete = 1'b0;
    step(1); e.inDeq = 1'b1; e.routeEn = 1'b1; want(); InputRoutingComplete = 1'b1; InputBT_Head = 36'h8;
    step(1); e.inDeq = 1'b0; e.routeEn = 1'b0; want();
    step(1); e.updEn = 4'hF; want();
    step(1); e.updEn = 4'h0; e.intEn = 1'b1; want();
    step(1); e.intEn = 1'b0; want();
    step(1); e.bt = 36'h8; want();
    step(1); e.inDeq = 1'b1; e.routeEn = 1'b1; want(); IsInputQueueEmpty = 1'b1;
    step(1); e.inDeq = 1'b0; e.routeEn = 1'b0; want();
    step(1); e.updEn = 4'hF; want();
    step(1); e.updEn = 4'h0; e.intEn = 1'b1; want();
    step(1); e.intEn = 1'b0; want();
    step(1); e.bt = 36'h10; want();
    step(2);

    // Aux priority, then staggered update completions in UPDATE cycles 2, 7, 7, 12.
    IsAuxQueueEmpty = 1'b0; AuxBT_Head = 36'h10; IsInputQueueEmpty = 1'b0; InputBT_Head = 36'h10;
    UpdateComplete = '0; InternalRoutingComplete = 1'b0; Run = 1'b1;
    step(1);
    step(1); e.auxDeq = 1'b1; e.sel = 1'b1; e.routeEn = 1'b1; want(); IsAuxQueueEmpty = 1'b1; Run = 1'b0;
    step(1); e.auxDeq = 1'b0; e.sel = 1'b0; e.routeEn = 1'b0; want();
    step(1); e.inDeq = 1'b1; e.routeEn = 1'b1; want(); IsInputQueueEmpty = 1'b1;
    step(1); e.inDeq = 1'b0; e.routeEn = 1'b0; want();
    step(1); e.updEn = 4'hF; want();
    step(1); UpdateComplete = 4'b0001;
    step(1); UpdateComplete = 4'b0000; e.updEn = 4'b1110; want();
    step(4); UpdateComplete = 4'b0110;
    step(1); UpdateComplete = 4'b0000; e.updEn = 4'b1000; want();
    step(4); UpdateComplete = 4'b1000;
    step(1); UpdateComplete = 4'b0000; e.updEn = 4'b0000; e.intEn = 1'b1; want();
    step(1); InternalRoutingComplete = 1'b1;
    step(1); InternalRoutingComplete = 1'b0; e.intEn = 1'b0; want();
    step(1); e.bt = 36'h18; want();
    step(1);

    // Wrap on the narrow instance: 4-cycle timesteps of +8, 56 -> 0, then stop in READY.
    wRun = 1'b1;
    step(2); chk("wrap_update_enable", 64'(wUpdEn), 64'd1);
    step(1); chk("wrap_update_drop", 64'({wUpdEn, wIntEn}), 64'b01);
    step(2); chk("wrap_bt_first_step", 64'(wBt), 64'd8);
    step(24); chk("wrap_bt_top", 64'(wBt), 64'd56); wRun = 1'b0;
    step(4); chk("wrap_bt_wrapped", 64'(wBt), 64'd0);
    step(7); chk("wrap_bt_stopped", 64'(wBt), 64'd0);
    chk("wrap_idle_outputs", 64'({wInDeq, wAuxDeq, wSel, wRouteEn, wMapN, wUpdEn, wIntEn, wTimeout}), 64'd0);
    chk("wrap_init_done", 64'(wInitDone), 64'd1);

    // Internal router never completes: watchdog (if built) fires, then reset mid-operation.
    UpdateComplete = '1; InternalRoutingComplete = 1'b0; Run = 1'b1;
    step(1);
    step(1); e.updEn = 4'hF; want(); Run = 1'b0;
    step(1); e.updEn = 4'h0; e.intEn = 1'b1; want();
`ifdef SYSCTRL_WATCHDOG_EN
    step(16); e.intEn = 1'b0; e.timeout = 1'b1; want();
`else
    step(16);
`endif
    step(1); Reset = 1'b0; e = '0; want();
    step(1); Reset = 1'b1;
    step(1); Initialize = 1'b1;
    step(1); Initialize = 1'b0; e.mapN = 1'b1; want();
    step(4);

    while (expQ.size() > 0) begin
      left = expQ.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_event: got no change, required cyc %0d snap %h", left.cyc, left.s);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sys_control_multi.md
# sys_control_multi

Parametrised successor to the single-neuron-unit system controller. It sequences initialization (neuron mapping), event routing from the input and aux queues, neuron update across `NUM_UNITS` parallel neuron units, and internal routing, once per biological timestep (BT). It also maintains the fixed-point current BT. It sits between the top level and the queues, the routers and the neuron-unit array.

## Interface

Parameters:
- `BT_WIDTH`, 36: width of BT values, unsigned fixed point, low `DELTAT_WIDTH` bits fractional.
- `DELTAT_WIDTH`, 4: fractional bits; width of `DeltaT`.
- `NUM_UNITS`, 4: number of neuron units, ≥1.
- `TIMEOUT_CYCLES`, 4096: watchdog limit; used only with `SYSCTRL_WATCHDOG_EN`.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low.
- `Initialize` in 1: start the mapping phase.
- `Run` in 1: permit timestep processing.
- `DeltaT` in `DELTAT_WIDTH`: BT increment, zero-extended.
- `IsInputQueueEmpty` in 1, `InputBT_Head` in `BT_WIDTH`: input FIFO status and head timestamp.
- `IsAuxQueueEmpty` in 1, `AuxBT_Head` in `BT_WIDTH`: aux FIFO status and head timestamp.
- `InputDequeue` out 1, `AuxDequeue` out 1: one-cycle pop pulses.
- `InputRouteInputSelect` out 1: 0 = input queue, 1 = aux queue.
- `InputRouteEnable` out 1, `InputRoutingComplete` in 1: input router handshake.
- `MapNeurons` out 1, `MappingComplete` in `NUM_UNITS`: per-unit mapping handshake.
- `UpdateEnable` out `NUM_UNITS`, `UpdateComplete` in `NUM_UNITS`: per-unit update handshake.
- `InternalRouteEnable` out 1, `InternalRoutingComplete` in 1: internal router handshake.
- `Current_BT` out `BT_WIDTH`: registered current BT.
- `InitializationComplete` out 1: sticky, high once mapping is done.
- `Timeout` out 1: watchdog error flag.

## Operation

- States: IDLE, INIT, READY, SELECT, ROUTE, UPDATE, INTERNAL, ADVANCE, ERROR.
- IDLE: `Initialize`=1 → INIT.
- INIT:
  - `MapNeurons`=1.
  - Per-unit sticky done flags are set by `MappingComplete[i]`.
  - When all flags are set (a same-cycle completion counts) → READY.
  - `InitializationComplete` goes high and stays high until reset.
- READY: `Run`=1 → SELECT.
- SELECT (one cycle), checked in priority order:
  - `!IsAuxQueueEmpty && AuxBT_Head <= Current_BT` → ROUTE with select=1.
  - Otherwise `!IsInputQueueEmpty && InputBT_Head <= Current_BT` → ROUTE with select=0.
  - Otherwise → UPDATE.
- ROUTE:
  - First cycle: dequeue pulse on the selected queue.
  - `InputRouteEnable`=1 and `InputRouteInputSelect` held stable until `InputRoutingComplete` is sampled high → SELECT.
- UPDATE:
  - On entry, `UpdateEnable`=all ones and the per-unit done flags clear.
  - `UpdateEnable[i]` drops the cycle after `UpdateComplete[i]` is seen.
  - All flags set → INTERNAL.
- INTERNAL: `InternalRouteEnable`=1 until `InternalRoutingComplete` → ADVANCE.
- ADVANCE (one cycle):
  - `Current_BT <= Current_BT + DeltaT`, wrapping modulo 2^`BT_WIDTH`.
  - If `Run`=0 and both queues are empty → READY; otherwise → SELECT.
- Completion inputs are ignored outside their wait state.
- `Run` is sampled only in READY and ADVANCE.
- ERROR: all enables 0, `Timeout`=1; exit only via `Reset`.

## Timing

- Reset (async assert): state IDLE. All outputs are 0, including `Current_BT`, `InitializationComplete`, `Timeout`, `UpdateEnable` and the dequeues.
- All outputs are registered.
- SELECT → first ROUTE cycle: 1 clock. The dequeue pulse and `InputRouteEnable` rise on the same edge.
- The enable falls on the edge after the completion is sampled. Minimum ROUTE length: 1 cycle.
- `Current_BT` updates on the edge leaving ADVANCE. It is visible in the next SELECT.
- Minimum empty timestep (all completions tied high): SELECT, UPDATE, INTERNAL, ADVANCE = 4 cycles.
- Reset asserted mid-operation clears every flag and returns to IDLE immediately. `InitializationComplete` is lost.

## Configuration

- `SYSCTRL_WATCHDOG_EN` defined:
  - A 32-bit cycle counter counts in INIT, ROUTE, UPDATE and INTERNAL, and clears on every state change.
  - Reaching `TIMEOUT_CYCLES` → ERROR.
- Undefined:
  - No counter and no ERROR state.
  - `Timeout` is tied to 0.
  - Wait states wait indefinitely.

## Test plan

- Init: `NUM_UNITS`=4, `MappingComplete` bits arrive in cycles 3, 5, 5 and 9 → `InitializationComplete` rises the cycle after bit 9 and `MapNeurons` falls.
- Input routing: `Current_BT`=0, input head=0 for two events → two `InputDequeue` pulses, select=0. Then with head=0x8 (0.5) → UPDATE, then `Current_BT`=0x8 after ADVANCE.
- Aux priority: both queues non-empty with heads equal to `Current_BT` → aux routed first (select=1, `AuxDequeue`), then input.
- Staggered update: `UpdateComplete` arrives per unit in cycles 2, 7, 7 and 12 → each `UpdateEnable[i]` drops individually. INTERNAL is entered only after cycle 12.
- Stop and wrap: `Current_BT`=2^36−8, `DeltaT`=8 → wraps to 0. With `Run`=0 and both queues empty at ADVANCE → READY.
- With `SYSCTRL_WATCHDOG_EN` and `TIMEOUT_CYCLES`=16: `InternalRoutingComplete` held at 0 → `Timeout`=1 at the 16th INTERNAL cycle and all enables are 0. `Reset` low clears it.
